ifetch_queue: RTL and testbench

- Instruction fetch stage sitting directly upstream of the instruction cache.
- Holds the PC and drives the cache CPU-side request/address.
- Captures returned instructions into a small show-ahead FIFO that feeds decode.
- Handles redirects (branch/exception) and never disturbs the cache address while a miss is outstanding.

---
 rtl/ifetch_queue.sv | 143 ++++++++++++++
 tb/tb_ifetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, issues icache requests and buffers
// returned instructions in a show-ahead FIFO feeding decode.
module ifetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    WORD_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_i,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc_i,
    output logic                        cpu_req_o,
    output logic [ADDR_WIDTH-1:0]       cpu_addr_o,
    input  logic                        cpu_valid_i,
    input  logic [WORD_WIDTH-1:0]       cpu_inst_i,
    output logic                        dec_valid_o,
    input  logic                        dec_ready_i,
    output logic [ADDR_WIDTH-1:0]       dec_pc_o,
    output logic [WORD_WIDTH-1:0]       dec_inst_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t                  state;
    logic                    run;
    logic                    pending;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   drop_target;

    logic [CW-1:0]           count;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [ADDR_WIDTH-1:0]   mem_pc   [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]   mem_inst [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0]   redirect_tgt;
    logic                    accept;
    logic                    miss_out;
    logic                    push;
    logic                    pop;

    assign redirect_tgt = redirect_pc_i & ~ADDR_WIDTH'(3);

    // run holds the request off until the first edge after reset release
    assign cpu_req_o  = run && (pending || (state == DRAIN) || (count < DEPTH_C));
    assign cpu_addr_o = pc;

    assign accept   = cpu_req_o && cpu_valid_i;
    assign miss_out = cpu_req_o && !cpu_valid_i;
    assign push     = (state == FETCH) && accept && !redirect_i;

    assign dec_valid_o  = (count != '0);
    assign dec_pc_o     = dec_valid_o ? mem_pc[rd_ptr]   : '0;
    assign dec_inst_o   = dec_valid_o ? mem_inst[rd_ptr] : '0;
    assign fifo_count_o = count;
    assign pop          = dec_valid_o && dec_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            run         <= 1'b0;
            pending     <= 1'b0;
            pc          <= RESET_PC;
            drop_target <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                FETCH: begin
                    if (redirect_i) begin
                        // A miss still in flight must finish on the old address
                        // before the cache may see the new one.
                        if (miss_out) begin
                            state       <= DRAIN;
                            drop_target <= redirect_tgt;
                            pending     <= 1'b1;
                        end else begin
                            pc      <= redirect_tgt;
                            pending <= 1'b0;
                        end
                    end else if (accept) begin
                        pc      <= pc + ADDR_WIDTH'(4);
                        pending <= 1'b0;
                    end else if (cpu_req_o) begin
                        pending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (redirect_i) begin
                        drop_target <= redirect_tgt;
                    end
                    if (cpu_valid_i) begin
                        pc          <= redirect_i ? redirect_tgt : drop_target;
                        state       <= FETCH;
                        pending     <= 1'b0;
                        drop_target <= '0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pc;
            mem_inst[wr_ptr] <= cpu_inst_i;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Vector-table bench for ifetch_queue with a scoreboard of expected decode
// entries; ends with a reset-during-miss sequence.
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        cpu_req_o;
    logic [31:0] cpu_addr_o;
    logic        cpu_valid_i;
    logic [31:0] cpu_inst_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_inst_o;
    logic [2:0]  fifo_count_o;

    ifetch_queue #(
        .ADDR_WIDTH (32),
        .WORD_WIDTH (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .cpu_req_o     (cpu_req_o),
        .cpu_addr_o    (cpu_addr_o),
        .cpu_valid_i   (cpu_valid_i),
        .cpu_inst_i    (cpu_inst_i),
        .dec_valid_o   (dec_valid_o),
        .dec_ready_i   (dec_ready_i),
        .dec_pc_o      (dec_pc_o),
        .dec_inst_o    (dec_inst_o),
        .fifo_count_o  (fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // icache data path: returns a deterministic word for whatever address is presented
    always_comb cpu_inst_i = inst_of(cpu_addr_o);

    typedef struct {
        bit          rdr;
        logic [31:0] rpc;
        bit          vld;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        int          cnt;
        bit          push;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t vecs[$];
    ent_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input bit rdr, input logic [31:0] rpc, input bit vld, input bit rdy,
                       input bit req, input logic [31:0] addr, input int cnt, input bit push);
        vec_t v;
        v.rdr = rdr; v.rpc = rpc; v.vld = vld; v.rdy = rdy;
        v.req = req; v.addr = addr; v.cnt = cnt; v.push = push;
        vecs.push_back(v);
    endtask

    task automatic check_head(input string tag, input int cnt);
        chk({tag, "_dvalid"}, 64'(dec_valid_o), 64'(cnt != 0));
        if (cnt != 0) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'(1));
            end else begin
                chk({tag, "_dec_pc"},   64'(dec_pc_o),   64'(sb[0].pc));
                chk({tag, "_dec_inst"}, 64'(dec_inst_o), 64'(sb[0].inst));
            end
        end else begin
            chk({tag, "_dec_pc0"},   64'(dec_pc_o),   64'(0));
            chk({tag, "_dec_inst0"}, 64'(dec_inst_o), 64'(0));
        end
    endtask

    initial begin
        ent_t e;
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        cpu_valid_i   = 1'b0;
        dec_ready_i   = 1'b0;

        // sequential fill, back-pressure, single pop
        add(0, 0, 1, 0, 1, 32'h100, 0, 1);
        add(0, 0, 1, 0, 1, 32'h104, 1, 1);
        add(0, 0, 1, 0, 1, 32'h108, 2, 1);
        add(0, 0, 1, 0, 1, 32'h10C, 3, 1);
        add(0, 0, 1, 0, 0, 32'h110, 4, 0);
        add(0, 0, 1, 1, 0, 32'h110, 4, 0);
        add(0, 0, 1, 0, 1, 32'h110, 3, 1);
        add(0, 0, 1, 0, 0, 32'h114, 4, 0);
        add(0, 0, 1, 1, 0, 32'h114, 4, 0);
        // redirect with 3 queued and a same-cycle hit
        add(1, 32'h40, 1, 0, 1, 32'h114, 3, 0);
        add(0, 0, 1, 1, 1, 32'h040, 0, 1);
        add(1, 32'h200, 1, 1, 1, 32'h044, 1, 0);
        // six-cycle miss on 0x200
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 1, 32'h200, 0, 0);
        add(0, 0, 1, 0, 1, 32'h200, 0, 1);
        add(0, 0, 1, 1, 1, 32'h204, 1, 1);
        // redirect coinciding with a miss start
        add(1, 32'h200, 0, 0, 1, 32'h208, 1, 0);
        add(0, 0, 0, 0, 1, 32'h208, 0, 0);
        add(0, 0, 1, 0, 1, 32'h208, 0, 0);
        // miss on 0x200, two redirects during the drain
        add(0, 0, 0, 0, 1, 32'h200, 0, 0);
        add(0, 0, 0, 0, 1, 32'h200, 0, 0);
        add(1, 32'h403, 0, 0, 1, 32'h200, 0, 0);
        add(0, 0, 0, 0, 1, 32'h200, 0, 0);
        add(1, 32'h800, 0, 0, 1, 32'h200, 0, 0);
        add(0, 0, 1, 0, 1, 32'h200, 0, 0);
        add(0, 0, 1, 0, 1, 32'h800, 0, 1);
        // address wrap, then single redirect during a miss
        add(1, 32'hFFFF_FFF8, 1, 0, 1, 32'h804, 1, 0);
        add(0, 0, 1, 0, 1, 32'hFFFF_FFF8, 0, 1);
        add(0, 0, 1, 0, 1, 32'hFFFF_FFFC, 1, 1);
        add(0, 0, 0, 0, 1, 32'h0000_0000, 2, 0);
        add(1, 32'h403, 0, 1, 1, 32'h0000_0000, 2, 0);
        add(0, 0, 0, 0, 1, 32'h0000_0000, 0, 0);
        add(0, 0, 1, 0, 1, 32'h0000_0000, 0, 0);
        add(0, 0, 1, 0, 1, 32'h400, 0, 1);
        add(0, 0, 1, 1, 1, 32'h404, 1, 1);
        add(0, 0, 0, 0, 1, 32'h408, 1, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   64'(cpu_req_o),    64'(0));
        chk("rst_addr",  64'(cpu_addr_o),   64'(32'h100));
        chk("rst_count", 64'(fifo_count_o), 64'(0));
        check_head("rst", 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            redirect_i    = vecs[i].rdr;
            redirect_pc_i = vecs[i].rpc;
            cpu_valid_i   = vecs[i].vld;
            dec_ready_i   = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_req", i),   64'(cpu_req_o),    64'(vecs[i].req));
            chk($sformatf("v%0d_addr", i),  64'(cpu_addr_o),   64'(vecs[i].addr));
            chk($sformatf("v%0d_count", i), 64'(fifo_count_o), 64'(vecs[i].cnt));
            check_head($sformatf("v%0d", i), vecs[i].cnt);
            if (vecs[i].rdy && vecs[i].cnt != 0 && sb.size() != 0) void'(sb.pop_front());
            if (vecs[i].rdr) sb.delete();
            if (vecs[i].push) begin
                e.pc   = vecs[i].addr;
                e.inst = inst_of(vecs[i].addr);
                sb.push_back(e);
            end
        end

        // reset asserted mid-miss (0x408 outstanding): outputs drop without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req",   64'(cpu_req_o),    64'(0));
        chk("midrst_addr",  64'(cpu_addr_o),   64'(32'h100));
        chk("midrst_count", 64'(fifo_count_o), 64'(0));
        sb.delete();
        check_head("midrst", 0);

        @(negedge clk);
        rst_n       = 1'b1;
        redirect_i  = 1'b0;
        cpu_valid_i = 1'b1;
        dec_ready_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rerun_req",   64'(cpu_req_o),    64'(1));
        chk("rerun_addr",  64'(cpu_addr_o),   64'(32'h100));
        chk("rerun_count", 64'(fifo_count_o), 64'(0));
        e.pc   = 32'h100;
        e.inst = inst_of(32'h100);
        sb.push_back(e);
        @(negedge clk);
        #1;
        chk("rerun2_addr",  64'(cpu_addr_o),   64'(32'h104));
        chk("rerun2_count", 64'(fifo_count_o), 64'(1));
        check_head("rerun2", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
